// File: rtl/imem_loader_if.sv
// Byte-stream / imem-write bundle for imem_loader. The host drives the master
// modport; the loader uses the slave modport.
interface imem_loader_if #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [DWIDTH-1:0]     imem_data;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_we;
  logic [15:0]           words_written;
  logic                  busy;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_data, imem_addr, imem_we, words_written,
           busy, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_data, imem_addr, imem_we, words_written,
           busy, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian 16-bit words from a byte stream and writes
// them to consecutive imem addresses. Define IMEM_LOAD_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
  parameter int                    DWIDTH     = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOAD_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            lo_q, lo_d;
  logic [DWIDTH-1:0]     data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic                  byte_ready;
  logic                  xfer;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: byte_ready = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHK:                                    byte_ready = 1'b1;
`endif
      default:                                  byte_ready = 1'b0;
    endcase
  end

  assign xfer = bus.byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    data_d  = data_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
    if (xfer && state_q != S_CHK) csum_d = csum_q ^ bus.byte_in;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          idx_d   = '0;
          wcnt_d  = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.byte_in;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.byte_in;
          state_d     = ({bus.byte_in, len_q[7:0]} == 16'h0000) ? S_FINAL : S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          lo_d    = bus.byte_in;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        // Word and address are registered here so WRITE drives imem purely from flops.
        if (xfer) begin
          data_d  = {bus.byte_in, lo_q};
          addr_d  = BASE_ADDR + idx_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        wcnt_d  = wcnt_q + 16'd1;
        state_d = (wcnt_q + 16'd1 == len_q) ? S_FINAL : S_DATA_LO;
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          err_d   = (bus.byte_in != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      addr_q  <= BASE_ADDR;
      idx_q   <= '0;
      wcnt_q  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.byte_ready    = byte_ready;
  assign bus.imem_data     = data_q;
  assign bus.imem_addr     = addr_q;
  assign bus.imem_we       = (state_q == S_WRITE);
  assign bus.words_written = wcnt_q;
  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.cpu_hold      = bus.busy;
  assign bus.done          = (state_q == S_DONE);
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign bus.error         = err_q;
`else
  assign bus.error         = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 0xFFFF) share one byte stream;
// a frame-level model predicts every imem write and the end-of-load status.
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] ww;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;

  int vecs = 0;
  int errs = 0;
  wr_t exp0[$], exp1[$], log0[$], log1[$];
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if #(.DWIDTH(16), .ADDR_WIDTH(16)) bus0 ();
  imem_loader_if #(.DWIDTH(16), .ADDR_WIDTH(16)) bus1 ();

  assign bus0.start = start;
  assign bus0.byte_in = byte_in;
  assign bus0.byte_valid = byte_valid;
  assign bus1.start = start;
  assign bus1.byte_in = byte_in;
  assign bus1.byte_valid = byte_valid;

  imem_loader #(.DWIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  imem_loader #(.DWIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected write queues.
  task automatic mon(input int k, input logic we, input logic [15:0] ad, input logic [15:0] dt,
                     input logic [15:0] ww, input logic rdy, input logic bsy, input logic hold,
                     input logic dn);
    wr_t e;
    wr_t g;
    int  n;
    check($sformatf("hold_eq_busy%0d", k), 32'(hold), 32'(bsy));
    check($sformatf("done_not_busy%0d", k), 32'(dn & bsy), 0);
    if (we) begin
      check($sformatf("ready_in_write%0d", k), 32'(rdy), 0);
      g.a = ad; g.d = dt; g.ww = ww;
      if (k == 0) log0.push_back(g); else log1.push_back(g);
      n = (k == 0) ? exp0.size() : exp1.size();
      if (n == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write%0d: got addr %h data %h expected no write", k, ad, dt);
      end else begin
        if (k == 0) e = exp0.pop_front(); else e = exp1.pop_front();
        check($sformatf("wr_addr%0d", k), 32'(ad), 32'(e.a));
        check($sformatf("wr_data%0d", k), 32'(dt), 32'(e.d));
        check($sformatf("wr_count%0d", k), 32'(ww), 32'(e.ww));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus0.imem_we, bus0.imem_addr, bus0.imem_data, bus0.words_written,
          bus0.byte_ready, bus0.busy, bus0.cpu_hold, bus0.done);
      mon(1, bus1.imem_we, bus1.imem_addr, bus1.imem_data, bus1.words_written,
          bus1.byte_ready, bus1.busy, bus1.cpu_hold, bus1.done);
    end
  end

  function automatic bq_t add_cks(input bq_t f);
    bq_t r;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = f;
`ifdef IMEM_LOAD_CHECKSUM_EN
    x = '0;
    foreach (f[i]) x ^= f[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  // Frame-level model: word i = {HI,LO} at base+i; error if a trailing byte mismatches the XOR.
  int unsigned exp_n = 0;
  task automatic model_frame(input bq_t fr);
    int unsigned n, full, sz, body;
    logic [7:0]  x;
    wr_t         w;
    sz   = fr.size();
    n    = {24'h0, fr[1], fr[0]};
    full = (sz - 2) / 2;
    if (full > n) full = n;
    for (int unsigned i = 0; i < full; i++) begin
      w.d  = {fr[3 + 2 * i], fr[2 + 2 * i]};
      w.ww = 16'(i);
      w.a  = 16'(i);
      exp0.push_back(w);
      w.a  = 16'(32'hFFFF + i);
      exp1.push_back(w);
    end
    body = 2 + 2 * n;
    x = '0;
    for (int unsigned i = 0; i < body && i < sz; i++) x ^= fr[i];
    exp_err = (sz > body) && (fr[body] != x);
    exp_n = n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t fr, input bit toggle);
    int unsigned sz, budget;
    bit sent;
    sz = fr.size();
    for (int unsigned i = 0; i < sz; i++) begin
      budget = 0;
      sent = 1'b0;
      while (!sent) begin
        byte_in = fr[i];
        byte_valid = 1'b1;
        @(negedge clk);
        sent = bus0.byte_ready;
        @(posedge clk); #1;
        if (toggle) begin
          byte_valid = 1'b0;
          @(posedge clk); #1;
        end
        budget++;
        if (!sent && budget > 20) begin
          vecs++;
          errs++;
          $display("FAIL byte_accept_timeout: got no transfer of byte %0d expected one within 20 tries", i);
          byte_valid = 1'b0;
          return;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_done(input string tag);
    int unsigned c;
    c = 0;
    while (!bus0.done && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_done0"}, 32'(bus0.done), 1);
    check({tag, "_done1"}, 32'(bus1.done), 1);
    check({tag, "_ww0"}, 32'(bus0.words_written), exp_n);
    check({tag, "_ww1"}, 32'(bus1.words_written), exp_n);
    check({tag, "_busy0"}, 32'(bus0.busy), 0);
    check({tag, "_hold1"}, 32'(bus1.cpu_hold), 0);
    check({tag, "_err0"}, 32'(bus0.error), 32'(exp_err));
    check({tag, "_err1"}, 32'(bus1.error), 32'(exp_err));
    check({tag, "_pending0"}, exp0.size(), 0);
    check({tag, "_pending1"}, exp1.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(bus0.byte_ready), 0);
    check({tag, "_data"}, 32'(bus0.imem_data), 0);
    check({tag, "_addr0"}, 32'(bus0.imem_addr), 0);
    check({tag, "_addr1"}, 32'(bus1.imem_addr), 'hFFFF);
    check({tag, "_we"}, 32'(bus0.imem_we), 0);
    check({tag, "_ww"}, 32'(bus0.words_written), 0);
    check({tag, "_busy"}, 32'(bus0.busy), 0);
    check({tag, "_hold"}, 32'(bus1.cpu_hold), 0);
    check({tag, "_done"}, 32'(bus0.done), 0);
    check({tag, "_error"}, 32'(bus0.error), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t fr, part;
    int unsigned c;

    rst_n = 1'b0;
    #12;
    check_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word frame, byte_valid held high.
    check("t1_hold_idle", 32'(bus0.cpu_hold), 0);
    fr = add_cks({8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB});
    log0.delete(); log1.delete();
    model_frame(fr);
    pulse_start();
    check("t1_hold_after_start", 32'(bus0.cpu_hold), 1);
    send_bytes(fr, 1'b0);
    check_done("t1");
    check("t1_nwrites", log0.size(), 2);
    if (log0.size() == 2 && log1.size() == 2) begin
      check("t1_w0_addr", 32'(log0[0].a), 'h0000);
      check("t1_w0_data", 32'(log0[0].d), 'h1234);
      check("t1_w1_addr", 32'(log0[1].a), 'h0001);
      check("t1_w1_data", 32'(log0[1].d), 'hABCD);
      check("t1_b1_w0_addr", 32'(log1[0].a), 'hFFFF);
    end

    // Zero-length frame.
    fr = add_cks({8'h00, 8'h00});
    log0.delete(); log1.delete();
    model_frame(fr);
    pulse_start();
    check("t2_done_cleared", 32'(bus0.done), 0);
    send_bytes(fr, 1'b0);
    c = 0;
    while (!bus0.done && c < 3) begin
      @(posedge clk); #1;
      c++;
    end
    check("t2_done_within_3", 32'(bus0.done), 1);
    check_done("t2");
    check("t2_nwrites", log0.size(), 0);

    // One-word frame with byte_valid toggling.
    fr = add_cks({8'h01, 8'h00, 8'hEF, 8'hBE});
    log0.delete(); log1.delete();
    model_frame(fr);
    pulse_start();
    send_bytes(fr, 1'b1);
    check_done("t3");
    check("t3_nwrites", log0.size(), 1);
    if (log0.size() == 1) begin
      check("t3_w0_addr", 32'(log0[0].a), 'h0000);
      check("t3_w0_data", 32'(log0[0].d), 'hBEEF);
    end

    // Address wrap on the BASE_ADDR=0xFFFF instance.
    fr = add_cks({8'h02, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22});
    log0.delete(); log1.delete();
    model_frame(fr);
    pulse_start();
    send_bytes(fr, 1'b0);
    check_done("t4");
    if (log1.size() == 2) begin
      check("t4_w0_addr", 32'(log1[0].a), 'hFFFF);
      check("t4_w0_data", 32'(log1[0].d), 'h1111);
      check("t4_w1_addr", 32'(log1[1].a), 'h0000);
      check("t4_w1_data", 32'(log1[1].d), 'h2222);
    end else begin
      check("t4_nwrites", log1.size(), 2);
    end

    // start while busy is ignored; bytes offered in DONE are not taken.
    fr = add_cks({8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00});
    model_frame(fr);
    pulse_start();
    part = fr[0:3];
    send_bytes(part, 1'b0);
    pulse_start();
    part = fr[4:$];
    send_bytes(part, 1'b0);
    check_done("t5");
    byte_in = 8'h55;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("t5_ww_after_idle_bytes", 32'(bus0.words_written), 3);
    check("t5_done_after_idle_bytes", 32'(bus0.done), 1);

    // Reset after LEN_HI of a 4-word frame, then a full reload.
    pulse_start();
    send_bytes({8'h04, 8'h00}, 1'b0);
    check("t6_busy_before_rst", 32'(bus0.busy), 1);
    #3 rst_n = 1'b0;
    #1 check_reset("t6_rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    fr = add_cks({8'h04, 8'h00, 8'h01, 8'hA0, 8'h02, 8'hB0, 8'h03, 8'hC0, 8'h04, 8'hD0});
    log0.delete(); log1.delete();
    model_frame(fr);
    pulse_start();
    send_bytes(fr, 1'b0);
    check_done("t6");
    if (log0.size() == 4) begin
      check("t6_w3_addr", 32'(log0[3].a), 'h0003);
      check("t6_w3_data", 32'(log0[3].d), 'hD004);
    end else begin
      check("t6_nwrites", log0.size(), 4);
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Explicit checksum bytes: 01^00^34^12 = 27.
    fr = {8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
    model_frame(fr);
    pulse_start();
    send_bytes(fr, 1'b0);
    check_done("t7");
    check("t7_error_lit", 32'(bus0.error), 0);

    fr = {8'h01, 8'h00, 8'h34, 8'h12, 8'h00};
    model_frame(fr);
    pulse_start();
    send_bytes(fr, 1'b0);
    check_done("t8");
    check("t8_error_lit", 32'(bus0.error), 1);
    check("t8_done_lit", 32'(bus0.done), 1);
    pulse_start();
    check("t8_error_cleared", 32'(bus0.error), 0);
    fr = add_cks({8'h00, 8'h00});
    model_frame(fr);
    send_bytes(fr, 1'b0);
    check_done("t9");
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader that sits directly upstream of the instruction memory and drives its data, address and write-enable inputs.
- Accepts a byte stream from a host link such as a UART receiver, assembles little-endian 16-bit instruction words, and writes them to consecutive imem addresses.
- Holds the processor core off the fetch path (cpu_hold) while a load is in progress.

Parameters:
- DWIDTH, 16, instruction word width; fixed at 16 (two bytes per word).
- ADDR_WIDTH, 16, imem address width; must match the imem instance.
- BASE_ADDR, 0, first imem address written by every load.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs on the edge where byte_valid and byte_ready are both 1.
- imem_data  output  DWIDTH  word to imem data input.
- imem_addr  output  ADDR_WIDTH  to imem addr.
- imem_we  output  1  to imem we.
- words_written  output  16  count of words written in the current/last load.
- busy  output  1  load in progress.
- cpu_hold  output  1  equals busy; stalls core fetch.
- done  output  1  high in DONE until next start.
- error  output  1  checksum error (see Optional Feature); tied 0 when the feature is off.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; imem_addr=BASE_ADDR; internal length, index and byte latches cleared. Reset mid-load abandons the load immediately; words already written stay in imem.
- Stream frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N pairs (LO byte, HI byte), each word = {HI,LO}.
- States:
  - IDLE: byte_ready=0. start -> LEN_LO; clear words_written, error, done.
  - LEN_LO: byte_ready=1. On transfer, latch low byte of N -> LEN_HI.
  - LEN_HI: byte_ready=1. On transfer, latch high byte. If N==0 -> DONE (CHK if feature on); else -> DATA_LO.
  - DATA_LO: byte_ready=1. On transfer, latch low byte -> DATA_HI.
  - DATA_HI: byte_ready=1. On transfer, latch high byte -> WRITE.
  - WRITE: byte_ready=0.
    - imem_we=1 for exactly this one cycle; imem_data={HI,LO}; imem_addr=BASE_ADDR+index, truncated modulo 2^ADDR_WIDTH (wrap-around allowed, no error).
    - At the end of the cycle, index and words_written increment.
    - If words_written+1==N -> DONE (CHK if feature on); else -> DATA_LO.
  - DONE: done=1, busy=0, byte_ready=0. start -> LEN_LO with counters cleared.
- busy=1 in all states except IDLE and DONE. cpu_hold=busy.
- imem_we is 0 in every state other than WRITE. imem_data/imem_addr hold their last values outside WRITE. All outputs are registered or decoded from registered state, so there is no combinational path from byte_valid to imem_we.
- Throughput: 3 cycles per word minimum (DATA_LO, DATA_HI, WRITE). byte_valid gaps of any length are tolerated; state holds.
- start while busy: ignored. byte_valid in IDLE/DONE: ignored, no transfer.
- Latency: first imem_we asserts 1 cycle after the transfer of word 0's HI byte.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - Adds state CHK after the last WRITE (or after LEN_HI when N==0).
  - A running XOR of all accepted bytes, length bytes included, is kept from LEN_LO onward.
  - CHK has byte_ready=1 and accepts one checksum byte. If it differs from the running XOR, error=1.
  - CHK -> DONE in either case. error holds until the next start or reset.
- Not defined: no CHK state; the frame ends at the last data word; error is constant 0.

Test Plan:
- Reset then start, stream 02 00 34 12 CD AB with byte_valid held 1 -> imem_we pulses twice: addr 0x0000 data 0x1234, then addr 0x0001 data 0xABCD; done=1; words_written=2; cpu_hold high from the cycle after start until DONE.
- Frame 00 00 -> no imem_we pulse; DONE within 3 cycles of LEN_HI transfer; words_written=0.
- Same 1-word frame 01 00 EF BE with byte_valid toggled 1/0 each cycle -> single write addr 0 data 0xBEEF; byte_ready low during WRITE; no byte is lost or duplicated.
- BASE_ADDR=0xFFFF, frame 02 00 11 11 22 22 -> writes 0xFFFF=0x1111 and 0x0000=0x2222 (wrap).
- rst_n asserted low after LEN_HI of a 4-word frame -> all outputs 0 asynchronously; a new start plus a full frame then loads correctly.
- With IMEM_LOAD_CHECKSUM_EN: frame 01 00 34 12 followed by checksum byte 0x27 -> error=0. The same frame followed by 0x00 -> error=1, done=1.
